// File: rtl/ps2_kbmatrix_pkg.sv
// Shared types and constants for the PS/2 to Z88 keyboard matrix front end.
// Holds the receiver FSM states, special scancodes and the keymap entry type.
package ps2_kbmatrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_APPLY
    } rx_state_t;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;
    localparam logic [7:0] CODE_ERR0   = 8'h00;
    localparam logic [7:0] CODE_BAT_OK = 8'hAA;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_BAT_NG = 8'hFC;
    localparam logic [7:0] CODE_RESEND = 8'hFE;
    localparam logic [7:0] CODE_ERR1   = 8'hFF;

    // Pause emits E1 followed by seven more bytes that carry no key meaning.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } keymap_entry_t;

    function automatic keymap_entry_t key_at(input logic [2:0] row, input logic [2:0] col);
        keymap_entry_t e;
        e.valid = 1'b1;
        e.row   = row;
        e.col   = col;
        return e;
    endfunction

    function automatic logic is_ignored(input logic [7:0] code);
        return (code == CODE_ERR0)   || (code == CODE_BAT_OK) || (code == CODE_ECHO) ||
               (code == CODE_ACK)    || (code == CODE_BAT_NG) || (code == CODE_RESEND) ||
               (code == CODE_ERR1);
    endfunction

endpackage

// File: rtl/ps2_z88_keymap.sv
// Combinational scancode-set-2 to Z88 matrix lookup, keyed on {ext, code}.
// Unlisted codes return an invalid entry.
module ps2_z88_keymap
    import ps2_kbmatrix_pkg::*;
(
    input  logic          ext,
    input  logic [7:0]    code,
    output keymap_entry_t entry
);

    always_comb begin
        entry = '0;
        case ({ext, code})
            // Row 7: RShift, Square, Esc, Index, Caps, . / pound
            9'h059: entry = key_at(3'd7, 3'd7);
            9'h011: entry = key_at(3'd7, 3'd6);
            9'h076: entry = key_at(3'd7, 3'd5);
            9'h006: entry = key_at(3'd7, 3'd4);
            9'h058: entry = key_at(3'd7, 3'd3);
            9'h049: entry = key_at(3'd7, 3'd2);
            9'h04A: entry = key_at(3'd7, 3'd1);
            9'h00E: entry = key_at(3'd7, 3'd0);
            // Row 6: Help, LShift, Tab, Diamond, Up, , ; Enter
            9'h005: entry = key_at(3'd6, 3'd7);
            9'h012: entry = key_at(3'd6, 3'd6);
            9'h00D: entry = key_at(3'd6, 3'd5);
            9'h014: entry = key_at(3'd6, 3'd4);
            9'h175: entry = key_at(3'd6, 3'd3);
            9'h041: entry = key_at(3'd6, 3'd2);
            9'h04C: entry = key_at(3'd6, 3'd1);
            9'h05A: entry = key_at(3'd6, 3'd0);
            // Row 5
            9'h054: entry = key_at(3'd5, 3'd7);
            9'h029: entry = key_at(3'd5, 3'd6);
            9'h016: entry = key_at(3'd5, 3'd5);
            9'h015: entry = key_at(3'd5, 3'd4);
            9'h01B: entry = key_at(3'd5, 3'd3);
            9'h01A: entry = key_at(3'd5, 3'd2);
            9'h04B: entry = key_at(3'd5, 3'd1);
            9'h045: entry = key_at(3'd5, 3'd0);
            // Row 4
            9'h05B: entry = key_at(3'd4, 3'd7);
            9'h16B: entry = key_at(3'd4, 3'd6);
            9'h01E: entry = key_at(3'd4, 3'd5);
            9'h01D: entry = key_at(3'd4, 3'd4);
            9'h01C: entry = key_at(3'd4, 3'd3);
            9'h022: entry = key_at(3'd4, 3'd2);
            9'h03A: entry = key_at(3'd4, 3'd1);
            9'h04D: entry = key_at(3'd4, 3'd0);
            // Row 3
            9'h04E: entry = key_at(3'd3, 3'd7);
            9'h174: entry = key_at(3'd3, 3'd6);
            9'h026: entry = key_at(3'd3, 3'd5);
            9'h024: entry = key_at(3'd3, 3'd4);
            9'h023: entry = key_at(3'd3, 3'd3);
            9'h021: entry = key_at(3'd3, 3'd2);
            9'h042: entry = key_at(3'd3, 3'd1);
            9'h046: entry = key_at(3'd3, 3'd0);
            // Row 2
            9'h055: entry = key_at(3'd2, 3'd7);
            9'h172: entry = key_at(3'd2, 3'd6);
            9'h025: entry = key_at(3'd2, 3'd5);
            9'h02D: entry = key_at(3'd2, 3'd4);
            9'h02B: entry = key_at(3'd2, 3'd3);
            9'h02A: entry = key_at(3'd2, 3'd2);
            9'h03B: entry = key_at(3'd2, 3'd1);
            9'h044: entry = key_at(3'd2, 3'd0);
            // Row 1: Menu sits on F3
            9'h05D: entry = key_at(3'd1, 3'd7);
            9'h004: entry = key_at(3'd1, 3'd6);
            9'h02E: entry = key_at(3'd1, 3'd5);
            9'h02C: entry = key_at(3'd1, 3'd4);
            9'h034: entry = key_at(3'd1, 3'd3);
            9'h032: entry = key_at(3'd1, 3'd2);
            9'h03C: entry = key_at(3'd1, 3'd1);
            9'h043: entry = key_at(3'd1, 3'd0);
            // Row 0: Del on Backspace
            9'h066: entry = key_at(3'd0, 3'd7);
            9'h052: entry = key_at(3'd0, 3'd6);
            9'h036: entry = key_at(3'd0, 3'd5);
            9'h035: entry = key_at(3'd0, 3'd4);
            9'h033: entry = key_at(3'd0, 3'd3);
            9'h031: entry = key_at(3'd0, 3'd2);
            9'h03D: entry = key_at(3'd0, 3'd1);
            9'h03E: entry = key_at(3'd0, 3'd0);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/ps2_kbmatrix.sv
// PS/2 keyboard receiver driving the active-low 64-bit Z88 keyboard matrix.
// Synchronise and filter the pins, assemble 11-bit frames, then decode prefixes and keys.
module ps2_kbmatrix
    import ps2_kbmatrix_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2clk,
    input  logic        ps2dat,
    output logic [63:0] kbmatrix,
    output logic [7:0]  ps2key,
    output logic        key_strobe,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST   = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    // Bit 1 carries ps2clk, bit 0 carries ps2dat through every stage.
    logic [1:0]    pin_p0, pin_p1;
    logic [1:0]    line_p2, line_p3;
    logic [FW-1:0] filt_cnt [2];

    rx_state_t     state;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tcnt;
    logic [10:0]   frame_sr;
    logic          ext, brk;
    logic [2:0]    skip_cnt;

    logic          fall;
    logic          dat_f;
    logic [7:0]    code;
    logic          frame_ok;
    keymap_entry_t entry;

    // p0/p1: two-flop synchroniser; p2: filtered lines; p3: previous filtered lines
    always_ff @(posedge clk) begin
        if (reset) begin
            pin_p0      <= 2'b11;
            pin_p1      <= 2'b11;
            line_p2     <= 2'b11;
            line_p3     <= 2'b11;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else begin
            pin_p0  <= {ps2clk, ps2dat};
            pin_p1  <= pin_p0;
            line_p3 <= line_p2;
            for (int i = 0; i < 2; i++) begin
                if (pin_p1[i] == line_p2[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FILT_LAST) begin
                    line_p2[i]  <= pin_p1[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + FW'(1);
                end
            end
        end
    end

    assign fall  = line_p3[1] & ~line_p2[1];
    assign dat_f = line_p2[0];
    assign code  = frame_sr[8:1];

    // Start bit low, stop bit high, and odd parity across data plus parity bit.
    assign frame_ok = ~frame_sr[0] & frame_sr[10] & (^frame_sr[9:1]);

    ps2_z88_keymap u_keymap (
        .ext   (ext),
        .code  (code),
        .entry (entry)
    );

    // Frame shift register: bits enter at the top and settle LSB-first.
    always_ff @(posedge clk) begin
        if (fall && (state == ST_IDLE || state == ST_RECV)) begin
            frame_sr <= {dat_f, frame_sr[10:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            tcnt       <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            skip_cnt   <= '0;
            kbmatrix   <= '1;
            ps2key     <= 8'h00;
            key_strobe <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            frame_err  <= 1'b0;

            if (fall) begin
                tcnt <= '0;
            end else if (state == ST_RECV) begin
                tcnt <= tcnt + TW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (fall && !dat_f) begin
                        state   <= ST_RECV;
                        bit_cnt <= 4'd1;
                    end
                end
                ST_RECV: begin
                    if (fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd10) begin
                            state <= ST_CHECK;
                        end
                    end else if (tcnt == TIMEOUT_MAX) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (frame_ok) begin
                        state <= ST_APPLY;
                    end else begin
                        frame_err <= 1'b1;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    ps2key     <= code;
                    key_strobe <= 1'b1;
                    state      <= ST_IDLE;
                    if (skip_cnt != 3'd0) begin
                        skip_cnt <= skip_cnt - 3'd1;
                    end else if (code == CODE_EXT) begin
                        ext <= 1'b1;
                    end else if (code == CODE_BRK) begin
                        brk <= 1'b1;
                    end else if (code == CODE_PAUSE) begin
                        skip_cnt <= PAUSE_SKIP;
                    end else if (!is_ignored(code)) begin
                        // Active-low matrix: a make drives the bit to 0, a break to 1.
                        if (entry.valid) begin
                            kbmatrix[{entry.row, entry.col}] <= brk;
                        end
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbmatrix.sv
// Directed bench for ps2_kbmatrix: drives PS/2 frames on the raw pins and checks
// the matrix, key byte and pulses against a byte-level behavioural model every cycle.
module tb_ps2_kbmatrix;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 16;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        ps2clk = 1'b1;
    logic        ps2dat = 1'b1;
    logic [63:0] kbmatrix;
    logic [7:0]  ps2key;
    logic        key_strobe;
    logic        frame_err;

    ps2_kbmatrix #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2dat     (ps2dat),
        .kbmatrix   (kbmatrix),
        .ps2key     (ps2key),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_err = 0;

    // Expected outcomes in arrival order: 0..255 a byte, -1 bad frame, -2 timeout.
    int exp_q [$];

    logic [63:0] m_mat = '1;
    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;
    int          m_skip = 0;

    function automatic int keypos(input logic ext, input logic [7:0] b);
        case ({ext, b})
            9'h01C:  return 35;
            9'h05A:  return 48;
            9'h012:  return 54;
            9'h059:  return 63;
            9'h175:  return 51;
            9'h014:  return 52;
            default: return -1;
        endcase
    endfunction

    task automatic model_apply(input logic [7:0] b);
        int p;
        if (m_skip > 0) begin
            m_skip = m_skip - 1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
            m_skip = 0;
        end else begin
            p = keypos(m_ext, b);
            if (p >= 0) m_mat[p] = m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2dat = f[i];
            repeat (HALF) @(posedge clk);
            ps2clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2clk = 1'b1;
        end
        ps2dat = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never arrived, want 0 pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(int'(b));
        send_bits(mkframe(b, 1'b0), 11);
        wait_drain(50, "frame_done");
    endtask

    task automatic send_bad(input logic [7:0] b);
        exp_q.push_back(-1);
        send_bits(mkframe(b, 1'b1), 11);
        wait_drain(50, "bad_frame_done");
    endtask

    initial begin
        int s0;
        int e0;

        fork
            begin
                int e;
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        m_mat  = '1;
                        m_ext  = 1'b0;
                        m_brk  = 1'b0;
                        m_skip = 0;
                    end else begin
                        if (key_strobe) begin
                            n_strobe++;
                            checks++;
                            if (exp_q.size() == 0 || exp_q[0] < 0) begin
                                errors++;
                                $display("FAIL unexpected_strobe: got ps2key %h want no strobe", ps2key);
                            end else begin
                                e = exp_q.pop_front();
                                if (ps2key !== e[7:0]) begin
                                    errors++;
                                    $display("FAIL ps2key: got %h want %h", ps2key, e[7:0]);
                                end
                                model_apply(e[7:0]);
                            end
                        end
                        if (frame_err) begin
                            n_err++;
                            checks++;
                            if (exp_q.size() == 0 || exp_q[0] >= 0) begin
                                errors++;
                                $display("FAIL unexpected_frame_err: got 1 want 0");
                            end else begin
                                e = exp_q.pop_front();
                                if (e == -1) begin
                                    m_ext = 1'b0;
                                    m_brk = 1'b0;
                                end
                            end
                        end
                        checks++;
                        if (kbmatrix !== m_mat) begin
                            errors++;
                            $display("FAIL kbmatrix_model: got %h want %h", kbmatrix, m_mat);
                        end
                    end
                end
            end
        join_none

        repeat (4) @(posedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_kbmatrix", kbmatrix, '1);
        chk("reset_ps2key", {56'd0, ps2key}, 64'h00);
        chk("reset_strobe", {63'd0, key_strobe}, 64'd0);
        chk("reset_frame_err", {63'd0, frame_err}, 64'd0);

        // Single make then break of A.
        s0 = n_strobe;
        send_byte(8'h1C);
        chk("a_make", kbmatrix, 64'hFFFF_FFF7_FFFF_FFFF);
        chk("a_ps2key", {56'd0, ps2key}, 64'h1C);
        chk("a_strobes", 64'(n_strobe - s0), 64'd1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("a_break", kbmatrix, '1);

        // Two held keys, release one.
        send_byte(8'h12);
        send_byte(8'h1C);
        chk("shift_a_held", kbmatrix, 64'hFFBF_FFF7_FFFF_FFFF);
        send_byte(8'hF0);
        send_byte(8'h12);
        chk("shift_released", kbmatrix, 64'hFFFF_FFF7_FFFF_FFFF);
        send_byte(8'hF0);
        send_byte(8'h1C);

        // Extended Up versus plain keypad code.
        send_byte(8'hE0);
        send_byte(8'h75);
        chk("up_make", kbmatrix, 64'hFFF7_FFFF_FFFF_FFFF);
        send_byte(8'h75);
        chk("plain_75", kbmatrix, 64'hFFF7_FFFF_FFFF_FFFF);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("up_break", kbmatrix, '1);

        // Parity error then the good frame.
        e0 = n_err;
        send_bad(8'h5A);
        chk("parity_err_count", 64'(n_err - e0), 64'd1);
        chk("parity_err_matrix", kbmatrix, '1);
        send_byte(8'h5A);
        chk("enter_make", kbmatrix, 64'hFFFE_FFFF_FFFF_FFFF);
        send_byte(8'hF0);
        send_byte(8'h5A);

        // Stalled frame times out, then a good frame still decodes.
        e0 = n_err;
        exp_q.push_back(-2);
        send_bits(mkframe(8'h1C, 1'b0), 5);
        repeat (TIMEOUT_CYCLES + 10) @(posedge clk);
        wait_drain(100, "timeout_done");
        chk("timeout_err_count", 64'(n_err - e0), 64'd1);
        send_byte(8'h1C);
        chk("after_timeout_make", kbmatrix, 64'hFFFF_FFF7_FFFF_FFFF);
        send_byte(8'hF0);
        send_byte(8'h1C);

        // Pause sequence leaves the matrix untouched.
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        chk("pause_matrix", kbmatrix, '1);
        chk("pause_ps2key", {56'd0, ps2key}, 64'h77);

        // Short clock glitches with data low must not start a frame.
        s0 = n_strobe;
        e0 = n_err;
        ps2dat = 1'b0;
        repeat (HALF) @(posedge clk);
        for (int g = 0; g < 6; g++) begin
            ps2clk = 1'b0;
            repeat ((g % 2 == 0) ? 1 : FILTER_LEN - 1) @(posedge clk);
            ps2clk = 1'b1;
            repeat (HALF) @(posedge clk);
        end
        ps2dat = 1'b1;
        repeat (HALF) @(posedge clk);
        chk("glitch_strobes", 64'(n_strobe - s0), 64'd0);
        chk("glitch_errs", 64'(n_err - e0), 64'd0);
        send_byte(8'h59);
        chk("rshift_make", kbmatrix, 64'h7FFF_FFFF_FFFF_FFFF);
        send_byte(8'hF0);
        send_byte(8'h59);

        // Reset during a partial frame.
        send_byte(8'h1C);
        send_bits(mkframe(8'h12, 1'b0), 4);
        @(posedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midreset_matrix", kbmatrix, '1);
        chk("midreset_ps2key", {56'd0, ps2key}, 64'h00);
        send_byte(8'h1C);
        chk("post_reset_make", kbmatrix, 64'hFFFF_FFF7_FFFF_FFFF);
        chk("post_reset_ps2key", {56'd0, ps2key}, 64'h1C);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbmatrix.md
# ps2_kbmatrix

Receives PS/2 keyboard frames on the raw `ps2clk`/`ps2dat` pins and maintains the 64-bit Z88 keyboard matrix consumed by the `z88` core (`kbmatrix`). It sits directly upstream of the core's keyboard port on the board top level and replaces ad-hoc PS/2 handling with a clean, single-clock design. It performs pin synchronisation, glitch filtering, frame assembly and checking, make/break and prefix decoding, and maps scancodes to matrix positions.

## Interface
- `FILTER_LEN`, 8: number of consecutive equal synchronised samples required before `ps2clk` or `ps2dat` changes filtered state.
- `TIMEOUT_CYCLES`, 100000: maximum `clk` cycles between filtered `ps2clk` falling edges inside a frame.
- `clk` input 1: master clock; the only clock.
- `reset` input 1: synchronous reset, active-high.
- `ps2clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2dat` input 1: raw PS/2 data pin, asynchronous.
- `kbmatrix` output 64: Z88 matrix, bit index = row*8+col, active-low (0 = pressed).
- `ps2key` output 8: last valid received byte.
- `key_strobe` output 1: one-cycle pulse when `ps2key` updates.
- `frame_err` output 1: one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Both pins pass through a 2-FF synchroniser, then a filter. The filter's output toggles only after `FILTER_LEN` consecutive opposite samples.
- A frame is a filtered `ps2clk` falling edge (fall). Data is sampled on each fall, LSB first, in this order: start(0), d0..d7, odd parity, stop(1).
- FSM states:
  - IDLE: a fall with data 0 goes to RECV with bit count 1. A fall with data 1 is ignored.
  - RECV: on each fall, shift the bit in and increment the count; after the 11th bit go to CHECK. If the timeout counter reaches `TIMEOUT_CYCLES`, pulse `frame_err` and go to IDLE.
  - CHECK: one cycle. A frame is bad if stop≠1 or parity is not odd. A bad frame pulses `frame_err`, clears all prefix flags, and goes to IDLE. A good frame goes to APPLY.
  - APPLY: one cycle. Update `ps2key` and pulse `key_strobe`, then process the byte and go to IDLE.
- Byte processing:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - 0xE1 loads a skip counter with 7. While the skip counter is nonzero, each byte only decrements it.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF are ignored.
  - Any other byte is looked up with {`ext`, byte}. If the entry is valid, the matrix bit is cleared (make) or set (`brk`). Both `ext` and `brk` are then cleared.
  - Unmapped codes change nothing but still clear the flags.
- Keymap entries:
  - 0x1C (A) → row 4 col 3 (bit 35).
  - 0x5A (Enter) → row 6 col 0 (bit 48).
  - 0x12 (LShift) → row 6 col 6 (bit 54).
  - 0x59 (RShift) → row 7 col 7 (bit 63).
  - E0 0x75 (Up) → row 6 col 3 (bit 51).
  - All other entries follow the Z88 matrix layout.
- Reset values: `kbmatrix` = all ones, `ps2key` = 0x00, `key_strobe` = 0, `frame_err` = 0, FSM = IDLE, flags and counters = 0. Filtered lines reset to 1 (idle bus).

## Timing
- Pin to filtered edge: 2 (sync) + `FILTER_LEN` cycles.
- Filtered fall of the stop bit = cycle N. CHECK occurs at N+1 and APPLY at N+2. `kbmatrix`, `ps2key` and `key_strobe` are visible at N+3.
- The timeout counter clears on every fall and counts only in RECV. A timeout returns the FSM to IDLE at the cycle the count equals `TIMEOUT_CYCLES`, with `frame_err` high that same cycle.
- A fall arriving during CHECK or APPLY is ignored. PS/2 bit periods (≥60 µs) make this unreachable in practice.
- Reset asserted mid-frame discards the partial frame and returns all outputs to reset values on the next edge.
- Make and break of the same key in consecutive frames each take effect independently. Multiple keys may be held.

## Structure
- Package `ps2_kbmatrix_pkg` holds:
  - the FSM state enum;
  - prefix and ignore-code constants (0xE0, 0xF0, 0xE1, ...);
  - the keymap entry type {valid, row[2:0], col[2:0]}.
- One combinational sub-module, `ps2_z88_keymap`: input {ext, code[7:0]}, output a keymap entry. It contains the full table.

## Test plan
- Send frame 0x1C with correct parity → `kbmatrix[35]`=0, all other bits 1, `ps2key`=0x1C, one `key_strobe`. Then send F0 1C → bit 35 returns to 1.
- Send 12 then 1C, then F0 12 → bits 54 and 35 are both 0 after the first two frames; after F0 12 only bit 35 is 0.
- Send E0 75 → bit 51 = 0. Send plain 0x75 → no change to bit 51.
- Send 0x5A with a wrong parity bit → `frame_err` pulses once and `kbmatrix` is unchanged. The next good 0x5A clears bit 48.
- Stop `ps2clk` after 5 bits for `TIMEOUT_CYCLES`+10 cycles → a `frame_err` pulse, FSM in IDLE. A following good 0x1C frame decodes correctly.
- Send the pause sequence E1 14 77 E1 F0 14 F0 77 → `kbmatrix` stays all ones. Inject 1-cycle glitches on `ps2clk` shorter than `FILTER_LEN` → no bit is shifted.
